// File: rtl/seg_scan_decoder.sv
// Receive side of a multiplexed 7-segment bus: decodes each scanned digit back to BCD and assembles NDIG-digit frames.
// Latency: 1 input register cycle, then SETTLE stable cycles to capture a digit; frame_valid 1 cycle after the last capture.
// Backpressure: none; this is a pure sink that samples the bus every cycle and never stalls the driver.

`ifndef NUMBER_0
`define NUMBER_0 8'h3F
`endif
`ifndef NUMBER_1
`define NUMBER_1 8'h06
`endif
`ifndef NUMBER_2
`define NUMBER_2 8'h5B
`endif
`ifndef NUMBER_3
`define NUMBER_3 8'h4F
`endif
`ifndef NUMBER_4
`define NUMBER_4 8'h66
`endif
`ifndef NUMBER_5
`define NUMBER_5 8'h6D
`endif
`ifndef NUMBER_6
`define NUMBER_6 8'h7D
`endif
`ifndef NUMBER_7
`define NUMBER_7 8'h07
`endif
`ifndef NUMBER_8
`define NUMBER_8 8'h7F
`endif
`ifndef NUMBER_9
`define NUMBER_9 8'h6F
`endif

module seg_scan_decoder #(
    parameter int NDIG        = 6,
    parameter int SETTLE      = 4,
    parameter bit SEL_ACT_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          number,
    input  logic [NDIG-1:0]     digit_block,
    output logic [4*NDIG-1:0]   digits,
    output logic                frame_valid,
    output logic [NDIG-1:0]     err_mask
);

    // Counter only has to reach SETTLE-1 (and the restart value 1).
    localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
    localparam logic [NDIG-1:0] SEL_ONE  = NDIG'(1);

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_COUNT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      w_cnt_next;

    logic [7:0]         r_number;
    logic [7:0]         r_number_d;
    logic [NDIG-1:0]    r_sel;
    logic [NDIG-1:0]    r_sel_d;

    logic [4*NDIG-1:0]  r_shadow;
    logic [NDIG-1:0]    r_shadow_err;
    logic [NDIG-1:0]    r_mask;

    logic               w_onehot;
    logic               w_sel_same;
    logic               w_num_same;
    logic               w_stable;
    logic               w_capture;
    logic               w_commit;
    logic [NDIG-1:0]    w_cap_bits;
    logic [NDIG-1:0]    w_mask_next;
    logic [3:0]         w_dec_val;
    logic               w_dec_err;

    // Input stage: register the bus once and keep one cycle of history for the stability check.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_number   <= 8'h00;
            r_number_d <= 8'h00;
            r_sel      <= '0;
            r_sel_d    <= '0;
        end else begin
            r_number   <= number;
            r_sel      <= SEL_ACT_LOW ? ~digit_block : digit_block;
            r_number_d <= r_number;
            r_sel_d    <= r_sel;
        end
    end

    // Select qualification: exactly one digit selected, and nothing moved since last cycle.
    always_comb begin
        w_onehot   = (r_sel != '0) && ((r_sel & (r_sel - SEL_ONE)) == '0);
        w_sel_same = (r_sel == r_sel_d);
        w_num_same = (r_number == r_number_d);
        w_stable   = w_onehot && w_sel_same && w_num_same;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // FSM next state: a fresh one-hot sample starts the settle count (or captures at once when SETTLE is 1).
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        case (r_state)
            S_WAIT: begin
                if (w_onehot) begin
                    if (SETTLE == 1) begin
                        w_capture    = 1'b1;
                        w_state_next = S_HOLD;
                    end else begin
                        w_cnt_next   = CNT_ONE;
                        w_state_next = S_COUNT;
                    end
                end
            end
            S_COUNT: begin
                if (!w_stable) begin
                    if (w_onehot) begin
                        if (SETTLE == 1) begin
                            w_capture    = 1'b1;
                            w_state_next = S_HOLD;
                        end else begin
                            w_cnt_next   = CNT_ONE;
                        end
                    end else begin
                        w_state_next = S_WAIT;
                    end
                end else if (r_cnt == CNT_LAST) begin
                    w_capture    = 1'b1;
                    w_state_next = S_HOLD;
                end else begin
                    w_cnt_next   = r_cnt + CNT_ONE;
                end
            end
            S_HOLD: begin
                if (!w_onehot) begin
                    w_state_next = S_WAIT;
                end else if (!w_sel_same || !w_num_same) begin
                    if (SETTLE == 1) begin
                        w_capture    = 1'b1;
                    end else begin
                        w_cnt_next   = CNT_ONE;
                        w_state_next = S_COUNT;
                    end
                end
            end
            default: begin
                w_state_next = S_WAIT;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Segment decoder: the full 8-bit pattern must match a code exactly; anything else is flagged as 4'hF.
    always_comb begin
        w_dec_val = 4'hF;
        w_dec_err = 1'b0;
        case (r_number)
            `NUMBER_0: w_dec_val = 4'd0;
            `NUMBER_1: w_dec_val = 4'd1;
            `NUMBER_2: w_dec_val = 4'd2;
            `NUMBER_3: w_dec_val = 4'd3;
            `NUMBER_4: w_dec_val = 4'd4;
            `NUMBER_5: w_dec_val = 4'd5;
            `NUMBER_6: w_dec_val = 4'd6;
            `NUMBER_7: w_dec_val = 4'd7;
            `NUMBER_8: w_dec_val = 4'd8;
            `NUMBER_9: w_dec_val = 4'd9;
            default: begin
                w_dec_val = 4'hF;
                w_dec_err = 1'b1;
            end
        endcase
    end

    // Frame bookkeeping: a capture made while committing belongs to the next frame.
    always_comb begin
        w_commit    = &r_mask;
        w_cap_bits  = w_capture ? r_sel : '0;
        w_mask_next = w_commit ? w_cap_bits : (r_mask | w_cap_bits);
    end

    // Shadow frame, capture mask and committed outputs; shadow is intentionally never cleared on commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shadow     <= '0;
            r_shadow_err <= '0;
            r_mask       <= '0;
            digits       <= '0;
            err_mask     <= '0;
            frame_valid  <= 1'b0;
        end else begin
            frame_valid <= w_commit;
            r_mask      <= w_mask_next;
            if (w_commit) begin
                digits   <= r_shadow;
                err_mask <= r_shadow_err;
            end
            if (w_capture) begin
                for (int i = 0; i < NDIG; i++) begin
                    if (r_sel[i]) begin
                        r_shadow[4*i +: 4] <= w_dec_val;
                        r_shadow_err[i]    <= w_dec_err;
                    end
                end
            end
        end
    end

endmodule
